// File: rtl/sync_fifo_buf_pkg.sv
// Shared widths, pointer/count types and the parity helper for sync_fifo_buf.
// SYNC_FIFO_PARITY_EN widens each stored word by one even-parity bit.
package fifo_pkg;
  localparam int DATA  = 14;
  localparam int ADDR  = 4;
  localparam int DEPTH = 1 << ADDR;
`ifdef SYNC_FIFO_PARITY_EN
  localparam int MEM_W = DATA + 1;
`else
  localparam int MEM_W = DATA;
`endif

  typedef logic [ADDR:0]   ptr_t;
  typedef logic [ADDR:0]   cnt_t;
  typedef logic [DATA-1:0] data_t;

  function automatic logic even_par(input logic [DATA-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/sync_fifo_buf_if.sv
// Push/pop handshake, data and status bundle of sync_fifo_buf.
interface sync_fifo_buf_if;
  import fifo_pkg::*;

  logic  winc;
  data_t wdata;
  logic  rinc;
  data_t rdata;
  logic  wfull;
  logic  wafull;
  logic  rempty;
  logic  raempty;
  cnt_t  count;
  logic  err_clr;
  logic  ovf;
  logic  udf;
  logic  rperr;

  modport master (
    output winc, wdata, rinc, err_clr,
    input  rdata, wfull, wafull, rempty, raempty, count, ovf, udf, rperr
  );

  modport slave (
    input  winc, wdata, rinc, err_clr,
    output rdata, wfull, wafull, rempty, raempty, count, ovf, udf, rperr
  );
endinterface

// File: rtl/sync_fifo_buf_ram.sv
// Word storage: synchronous write port, asynchronous read port (no reset on contents).
module fifo_ram #(
  parameter int W  = 14,
  parameter int AW = 4
) (
  input  logic          wclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge wclk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];
endmodule

// File: rtl/sync_fifo_buf.sv
// Single-clock first-word-fall-through FIFO with registered flags and sticky errors.
// Optional head-word parity check under SYNC_FIFO_PARITY_EN.
module sync_fifo_buf
  import fifo_pkg::*;
#(
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic      wclk,
  input  logic      wrst,
  sync_fifo_buf_if.slave bus
);
  if (!(AFULL_TH > 0 && AFULL_TH <= DEPTH && AEMPTY_TH >= 0 && AEMPTY_TH < DEPTH))
  begin : g_bad_param
    $error("sync_fifo_buf: illegal AFULL_TH/AEMPTY_TH");
  end

  ptr_t r_wptr, r_rptr;
  logic r_wfull, r_wafull, r_rempty, r_raempty;
  logic r_ovf, r_udf;

  logic w_push, w_pop;
  ptr_t w_wptr_nxt, w_rptr_nxt;
  cnt_t w_count, w_cnt_nxt;
  logic [MEM_W-1:0] w_wr_word, w_rd_word;

  // A push into a full FIFO is only allowed because the same-cycle pop frees a slot.
  assign w_push     = bus.winc && (!r_wfull || bus.rinc);
  assign w_pop      = bus.rinc && !r_rempty;
  assign w_wptr_nxt = r_wptr + ptr_t'(w_push);
  assign w_rptr_nxt = r_rptr + ptr_t'(w_pop);
  assign w_count    = r_wptr - r_rptr;
  assign w_cnt_nxt  = w_wptr_nxt - w_rptr_nxt;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_wfull   <= 1'b0;
      r_wafull  <= 1'b0;
      r_rempty  <= 1'b1;
      r_raempty <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      r_wfull   <= (w_cnt_nxt == cnt_t'(DEPTH));
      r_wafull  <= (w_cnt_nxt >= cnt_t'(AFULL_TH));
      r_rempty  <= (w_cnt_nxt == '0);
      r_raempty <= (w_cnt_nxt <= cnt_t'(AEMPTY_TH));
      r_ovf     <= (bus.winc && r_wfull && !bus.rinc) || (r_ovf && !bus.err_clr);
      r_udf     <= (bus.rinc && r_rempty) || (r_udf && !bus.err_clr);
    end
  end

`ifdef SYNC_FIFO_PARITY_EN
  assign w_wr_word = {even_par(bus.wdata), bus.wdata};
  assign bus.rperr = !r_rempty && (^w_rd_word);
`else
  assign w_wr_word = bus.wdata;
  assign bus.rperr = 1'b0;
`endif

  fifo_ram #(
    .W  (MEM_W),
    .AW (ADDR)
  ) u_ram (
    .wclk  (wclk),
    .we    (w_push),
    .waddr (r_wptr[ADDR-1:0]),
    .wdata (w_wr_word),
    .raddr (r_rptr[ADDR-1:0]),
    .rdata (w_rd_word)
  );

  assign bus.rdata   = w_rd_word[DATA-1:0];
  assign bus.count   = w_count;
  assign bus.wfull   = r_wfull;
  assign bus.wafull  = r_wafull;
  assign bus.rempty  = r_rempty;
  assign bus.raempty = r_raempty;
  assign bus.ovf     = r_ovf;
  assign bus.udf     = r_udf;
endmodule

// File: tb/tb_sync_fifo_buf.sv
// Bench for sync_fifo_buf: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo_buf;
  logic wclk = 1'b0;
  logic wrst;
  always #5 wclk = ~wclk;

  sync_fifo_buf_if bus();

  sync_fifo_buf #(.AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [13:0] q[$];
  bit m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"},   32'(bus.count),   32'(q.size()));
    check({tag, ".rempty"},  32'(bus.rempty),  32'(q.size() == 0));
    check({tag, ".wfull"},   32'(bus.wfull),   32'(q.size() == 16));
    check({tag, ".wafull"},  32'(bus.wafull),  32'(q.size() >= 14));
    check({tag, ".raempty"}, 32'(bus.raempty), 32'(q.size() <= 2));
    check({tag, ".ovf"},     32'(bus.ovf),     32'(m_ovf));
    check({tag, ".udf"},     32'(bus.udf),     32'(m_udf));
    check({tag, ".rperr"},   32'(bus.rperr),   32'd0);
    if (q.size() > 0) check({tag, ".rdata"}, 32'(bus.rdata), 32'(q[0]));
  endtask

  // One clock with the given request; model follows the FIFO's accept rules.
  task automatic cycle(input string tag, input bit winc, input bit rinc,
                       input logic [13:0] d, input bit clr = 1'b0);
    bit push_ok, pop_ok, ovf_set, udf_set;
    bus.winc = winc; bus.rinc = rinc; bus.wdata = d; bus.err_clr = clr;
    push_ok = winc && (q.size() < 16 || rinc);
    pop_ok  = rinc && q.size() > 0;
    ovf_set = winc && q.size() == 16 && !rinc;
    udf_set = rinc && q.size() == 0;
    @(posedge wclk);
    if (pop_ok)  void'(q.pop_front());
    if (push_ok) q.push_back(d);
    m_ovf = ovf_set || (m_ovf && !clr);
    m_udf = udf_set || (m_udf && !clr);
    #1;
    bus.winc = 1'b0; bus.rinc = 1'b0; bus.err_clr = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag, input bit busy);
    wrst = 1'b1;
    bus.winc = busy; bus.rinc = busy; bus.wdata = 14'h1555; bus.err_clr = 1'b0;
    @(posedge wclk);
    #1;
    wrst = 1'b0; bus.winc = 1'b0; bus.rinc = 1'b0;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    check_state(tag);
  endtask

  initial begin
    bus.winc = 1'b0; bus.rinc = 1'b0; bus.wdata = '0; bus.err_clr = 1'b0;
    wrst = 1'b1;
    repeat (2) @(posedge wclk);
    do_reset("rst", 1'b0);

    for (int i = 1; i <= 16; i++) begin
      cycle("t1_push", 1'b1, 1'b0, 14'(i));
      if (i == 13) check("t1_wafull13", 32'(bus.wafull), 32'd0);
      if (i == 14) check("t1_wafull14", 32'(bus.wafull), 32'd1);
    end
    check("t1_full_count", 32'(bus.count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      check("t1_pop_data", 32'(bus.rdata), 32'(i));
      cycle("t1_pop", 1'b0, 1'b1, '0);
    end
    check("t1_empty", 32'(bus.rempty), 32'd1);

    for (int i = 0; i < 16; i++) cycle("t2_fill", 1'b1, 1'b0, 14'($urandom));
    cycle("t2_ovf", 1'b1, 1'b0, 14'h3FFF);
    check("t2_ovf_set", 32'(bus.ovf), 32'd1);
    cycle("t2_clr", 1'b0, 1'b0, '0, 1'b1);
    check("t2_ovf_clr", 32'(bus.ovf), 32'd0);

    cycle("t3_pp_full", 1'b1, 1'b1, 14'h2AAA);
    check("t3_count", 32'(bus.count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) check("t3_tail", 32'(bus.rdata), 32'h2AAA);
      cycle("t3_pop", 1'b0, 1'b1, '0);
    end

    cycle("t4_pp_empty", 1'b1, 1'b1, 14'h0123);
    check("t4_udf", 32'(bus.udf), 32'd1);
    check("t4_rdata", 32'(bus.rdata), 32'h0123);
    cycle("t4_clr", 1'b0, 1'b0, '0, 1'b1);

    cycle("t5_fill", 1'b1, 1'b0, 14'($urandom));
    cycle("t5_fill", 1'b1, 1'b0, 14'($urandom));
    for (int i = 0; i < 40; i++) cycle("t5_wrap", 1'b1, 1'b1, 14'($urandom));
    check("t5_count", 32'(bus.count), 32'd3);

    for (int i = 0; i < 6; i++) cycle("t6_fill", 1'b1, 1'b0, 14'($urandom));
    check("t6_count9", 32'(bus.count), 32'd9);
    do_reset("t6_rst", 1'b1);

`ifdef SYNC_FIFO_PARITY_EN
    cycle("par_push", 1'b1, 1'b0, 14'h0F0F);
    cycle("par_push", 1'b1, 1'b0, 14'h0001);
    dut.u_ram.r_mem[dut.r_rptr[3:0]] = dut.u_ram.r_mem[dut.r_rptr[3:0]] ^ 15'h0004;
    #1;
    check("par_err", 32'(bus.rperr), 32'd1);
    cycle("par_pop", 1'b0, 1'b1, '0);
    do_reset("par_rst", 1'b0);
`endif

    // Random traffic in phases biased toward filling, draining and balanced use.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 400; i++) begin
        int pw, pr;
        pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
        pr = 100 - pw;
        if ($urandom_range(0, 499) == 0) do_reset("rnd_rst", 1'b1);
        else cycle("rnd", $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                   14'($urandom), $urandom_range(0, 15) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
